// File: rtl/serial_tx_arbiter.sv
// Two-requester, packet-locked round-robin arbiter in front of the UART TX.
// Holds a grant for a whole packet, spaces packets by a gap, revokes stalls.
module serial_tx_arbiter #(
    parameter int GAP_CYCLES     = 10417,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       USER_CLK,
    input  logic       CPU_RESET,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [TW-1:0] STALL_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PASS,
        S_GAP
    } state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_q, rr_d;
    logic [TW-1:0] stall_q, stall_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          tout_q, tout_d;

    logic [7:0] own_data;
    logic       own_valid;
    logic       own_last;
    logic       xfer;

    assign own_data  = owner_q ? s1_data : s0_data;
    assign own_valid = owner_q ? s1_valid : s0_valid;
    assign own_last  = owner_q ? s1_last : s0_last;

    assign timeout_err = tout_q;

    always_ff @(posedge USER_CLK) begin
        if (CPU_RESET) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            stall_q <= '0;
            gap_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            stall_q <= stall_d;
            gap_q   <= gap_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        stall_d  = stall_q;
        gap_d    = gap_q;
        tout_d   = 1'b0;
        xfer     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        grant    = 2'b00;
        busy     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (s0_valid || s1_valid) begin
                    owner_d = (s0_valid && s1_valid) ? rr_q : s1_valid;
                    stall_d = '0;
                    state_d = S_PASS;
                end
            end

            S_PASS: begin
                busy  = 1'b1;
                grant = owner_q ? 2'b10 : 2'b01;
                if (stall_q == STALL_MAX) begin
                    // Abandon cycle: path is closed so no stray byte slips in.
                    rr_d    = ~owner_q;
                    stall_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end else begin
                    tx_data  = own_data;
                    tx_valid = own_valid;
                    s0_ready = ~owner_q & tx_ready;
                    s1_ready = owner_q & tx_ready;
                    xfer     = own_valid & tx_ready;
                    if (xfer) begin
                        stall_d = '0;
                        if (own_last) begin
                            rr_d = ~owner_q;
                            if (GAP_CYCLES == 0) begin
                                state_d = S_IDLE;
                            end else begin
                                gap_d   = GAP_LOAD;
                                state_d = S_GAP;
                            end
                        end
                    end else if (!own_valid) begin
                        stall_d = stall_q + TW'(1);
                        tout_d  = (stall_d == STALL_MAX);
                    end
                end
            end

            S_GAP: begin
                busy = 1'b1;
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end
                if (gap_q <= GW'(1)) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
